// File: rtl/snake_pkg.sv
// Shared types for the snake display path: grid shape, flasher state encoding
// and a width helper for small saturating counters.
package snake_pkg;

   localparam int GRID_ROWS = 8;
   localparam int GRID_COLS = 8;

   typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0] grid_t;

   typedef enum logic [1:0] {FL_IDLE, FL_ON, FL_OFF, FL_HOLD} flash_state_t;

   // Bits needed to hold 0..max inclusive, never less than one.
   function automatic int cnt_width(input int max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/collision_flasher_if.sv
// Game-core <-> flasher bundle: collision/blink events and head grid in,
// orange-layer drive and status out.
interface collision_flasher_if
   import snake_pkg::*;
#(
   parameter int ROWS = GRID_ROWS,
   parameter int COLS = GRID_COLS
);
   logic                       tracking;
   logic                       snake;
   logic                       clear;
   logic [ROWS-1:0][COLS-1:0]  head_position;
   logic [ROWS-1:0][COLS-1:0]  orange_array;
   logic                       busy;
   logic                       done;

   modport master (
      output tracking, snake, clear, head_position,
      input  orange_array, busy, done
   );

   modport slave (
      input  tracking, snake, clear, head_position,
      output orange_array, busy, done
   );
endinterface

// File: rtl/blink_counter.sv
// Saturating up-counter with synchronous clear; tc flags that the count has
// reached MAX and stays high while it sits there.
module blink_counter
   import snake_pkg::*;
#(
   parameter int MAX = 3
) (
   input  logic Clock,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic tc
);
   localparam int W = cnt_width(MAX);

   logic [W-1:0] cnt;

   assign tc = (cnt == W'(MAX));

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && !tc)
         cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/collision_flasher.sv
// Captures the head grid on a collision pulse and blinks it on the orange
// layer, one display toggle per blink tick, then holds it steady until clear.
module collision_flasher
   import snake_pkg::*;
#(
   parameter int ROWS          = GRID_ROWS,
   parameter int COLS          = GRID_COLS,
   parameter int BLINK_COUNT   = 3,
   parameter int BLINK_FOREVER = 0
) (
   input  logic                Clock,
   input  logic                reset,
   collision_flasher_if.slave  bus
);
   localparam bit FOREVER = (BLINK_FOREVER != 0);

   flash_state_t              state, state_nx;
   logic [ROWS-1:0][COLS-1:0] snapshot;
   logic                      capture;
   logic                      cnt_clr;
   logic                      cnt_inc;
   logic                      cnt_tc;

   // Counts completed ON phases; tc tells OFF whether the last one has run.
   blink_counter #(
      .MAX (BLINK_COUNT)
   ) u_cnt (
      .Clock (Clock),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .tc    (cnt_tc)
   );

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) begin
         state    <= FL_IDLE;
         snapshot <= '0;
      end else begin
         state <= state_nx;
         if (bus.clear)
            snapshot <= '0;
         else if (capture)
            snapshot <= bus.head_position;
      end
   end

   // clear beats snake beats tracking; events outside their state are dropped.
   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      if (bus.clear) begin
         state_nx = FL_IDLE;
         cnt_clr  = 1'b1;
      end else begin
         case (state)
            FL_IDLE: if (bus.snake) begin
               state_nx = FL_ON;
               capture  = 1'b1;
               cnt_clr  = 1'b1;
            end
            FL_ON: if (bus.tracking) begin
               state_nx = FL_OFF;
               cnt_inc  = 1'b1;
            end
            FL_OFF: if (bus.tracking)
               state_nx = (!FOREVER && cnt_tc) ? FL_HOLD : FL_ON;
            FL_HOLD: state_nx = FL_HOLD;
            default: state_nx = FL_IDLE;
         endcase
      end
   end

   assign bus.orange_array = (state == FL_ON || state == FL_HOLD) ? snapshot : '0;
   assign bus.busy         = (state != FL_IDLE);
   assign bus.done         = (state == FL_HOLD);
endmodule

// File: doc/collision_flasher.md
Name: collision_flasher

Overview:
Parametrised successor to the snake collision highlighter. On a collision pulse it snapshots the head-position grid, then blinks that snapshot on the orange layer of the LED matrix, paced by the blink tick ("tracking"). It blinks for a programmable number of cycles, then shows the snapshot steady until cleared; a parameter can make it blink indefinitely instead. It sits between the snake game core and the LED matrix driver.

Parameters:
ROWS, 8, grid row count (>=1).
COLS, 8, grid column count (>=1).
BLINK_COUNT, 3, number of ON phases before going steady (>=1); ignored when BLINK_FOREVER=1.
BLINK_FOREVER, 0, 1 = blink until clear; 0 = go steady after BLINK_COUNT ON phases.

Ports:
Clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
tracking  input  1  blink tick, one-cycle pulse per blink half-period.
snake  input  1  collision pulse from game logic.
clear  input  1  synchronous return to idle (new game).
head_position  input  [ROWS-1:0][COLS-1:0]  one-hot-ish head grid.
orange_array  output  [ROWS-1:0][COLS-1:0]  orange-layer drive.
busy  output  1  high in ON, OFF and HOLD.
done  output  1  high only in HOLD.

Behaviour:
- Reset (reset=0, async): state=IDLE, snapshot=0, blink_cnt=0; orange_array=0, busy=0, done=0 immediately.
- State set: IDLE, ON, OFF, HOLD. All registers update on the rising edge of Clock.
- Priority each cycle: clear > snake > tracking.
- clear=1 in any state: next state IDLE, snapshot=0, blink_cnt=0.
- IDLE: snake=1 -> ON, snapshot<=head_position, blink_cnt<=0. tracking is ignored in IDLE, including when it arrives in the same cycle as snake.
- ON: tracking=1 -> OFF, blink_cnt<=blink_cnt+1. snake is ignored (no re-capture).
- OFF: tracking=1 -> if BLINK_FOREVER=0 and blink_cnt==BLINK_COUNT then HOLD, else ON. snake is ignored.
- HOLD: remains in HOLD until clear. snake and tracking are ignored.
- BLINK_FOREVER=1: blink_cnt saturates at its max value, and HOLD is never entered.
- Outputs are decoded combinationally from registered state and snapshot, so there are no output glitches from inputs.
  - orange_array = snapshot in ON or HOLD; otherwise 0.
  - busy = (state != IDLE).
  - done = (state == HOLD).
- Latency: snake sampled at edge k gives orange_array = captured head from cycle k+1 onward. Each tracking edge toggles the display on the next cycle.
- Snapshot is frozen at capture; later changes to head_position have no effect until IDLE is re-entered and a new snake pulse arrives.
- blink_cnt width = $clog2(BLINK_COUNT+1). It never wraps.
- Held tracking (multi-cycle high) counts as one event per cycle; the upstream tick generator is responsible for producing single-cycle pulses.
- Reset asserted mid-blink: outputs clear immediately and the block does not resume after reset deasserts.
- head_position=0 at capture: the state machine runs normally and the display stays dark.

Decomposition:
- Shared package snake_pkg:
  - typedef enum logic [1:0] {FL_IDLE, FL_ON, FL_OFF, FL_HOLD} flash_state_t
  - constants GRID_ROWS=8, GRID_COLS=8
  - typedef grid_t for the 8x8 packed array
- One natural sub-module: blink_counter (saturating up-counter with clear, terminal-count compare, parameter MAX).
- Snapshot register and state machine stay in collision_flasher.

Test Plan:
1. Reset: drive reset=0 mid-clock -> orange_array=0, busy=0, done=0 with no clock edge needed.
2. Basic blink, defaults (BLINK_COUNT=3): head_position[2][5]=1, one-cycle snake pulse, then 6 tracking pulses 4 cycles apart -> display sequence ON, OFF, ON, OFF, ON, OFF, then HOLD with orange_array[2][5]=1 and done=1.
3. Snapshot freeze: after capture of [2][5], move head_position to [3][5] -> orange_array still shows only [2][5] in ON and HOLD.
4. Simultaneous events:
   - snake and tracking in the same cycle in IDLE -> state ON, blink_cnt=0.
   - clear with snake in ON -> state IDLE, orange_array=0.
   - second snake pulse during OFF -> ignored, snapshot unchanged.
5. BLINK_FOREVER=1: 20 tracking pulses -> display alternates every pulse, done never rises; clear -> IDLE, busy=0.
6. Async reset mid-blink (in ON): reset low for 1 cycle -> outputs 0 at once; after release, IDLE persists with no blink until a new snake pulse.
